// File: rtl/dram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : dram_pkg                                                      |
// | Purpose    : Shared constants and types for the DRAM responder slice:      |
// |              default array/buffer sizing, per-core slice widths and the    |
// |              host-side FSM state encoding.                                 |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
package dram_pkg;

  localparam int c_ADDR_W   = 12;  // default array depth 2^12 bytes
  localparam int c_WB_DEPTH = 8;   // default posted-write buffer entries
  localparam int c_CORE_AW  = 16;  // per-core address slice width
  localparam int c_CORE_DW  = 8;   // per-core data slice width

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } host_state_t;

endpackage
`default_nettype wire

// File: rtl/dram_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface  : dram_responder_if                                             |
// | Purpose    : Host request/response handshake of the DRAM responder.        |
// | Signals    : i_host_valid/i_host_write/i_host_addr/i_host_wdata (request), |
// |              o_host_ready (accept), o_host_rvalid/o_host_rdata (response). |
// | Modports   : master (host side), slave (responder side).                   |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
interface dram_responder_if;
  import dram_pkg::*;

  logic                 i_host_valid;
  logic                 i_host_write;
  logic [c_CORE_AW-1:0] i_host_addr;
  logic [c_CORE_DW-1:0] i_host_wdata;
  logic                 o_host_ready;
  logic                 o_host_rvalid;
  logic [c_CORE_DW-1:0] o_host_rdata;

  modport master (
    output i_host_valid, i_host_write, i_host_addr, i_host_wdata,
    input  o_host_ready, o_host_rvalid, o_host_rdata
  );

  modport slave (
    input  i_host_valid, i_host_write, i_host_addr, i_host_wdata,
    output o_host_ready, o_host_rvalid, o_host_rdata
  );

endinterface
`default_nettype wire

// File: rtl/dram_wbuf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : dram_wbuf                                                     |
// | Purpose    : Circular posted-write FIFO. Up to NUM_ENQ entries enqueue per |
// |              cycle in index order, the oldest entry drains whenever the    |
// |              FIFO is non-empty, and NUM_LOOK ports return the youngest     |
// |              pending entry matching an address.                            |
// | Ports      : i_clk, i_rst; i_enq/i_enq_addr/i_enq_data (enqueue lanes);    |
// |              o_drain/o_head_addr/o_head_data (drain); o_count;             |
// |              i_look_addr/o_look_hit/o_look_data (forwarding lookups).      |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module dram_wbuf
  import dram_pkg::*;
#(
  parameter int NUM_ENQ  = 5,
  parameter int NUM_LOOK = 5,
  parameter int ADDR_W   = c_ADDR_W,
  parameter int DEPTH    = c_WB_DEPTH
) (
  input  wire logic                          i_clk,
  input  wire logic                          i_rst,
  input  wire logic [NUM_ENQ-1:0]            i_enq,
  input  wire logic [NUM_ENQ*ADDR_W-1:0]     i_enq_addr,
  input  wire logic [NUM_ENQ*c_CORE_DW-1:0]  i_enq_data,
  output logic                               o_drain,
  output logic [ADDR_W-1:0]                  o_head_addr,
  output logic [c_CORE_DW-1:0]               o_head_data,
  output logic [$clog2(DEPTH):0]             o_count,
  input  wire logic [NUM_LOOK*ADDR_W-1:0]    i_look_addr,
  output logic [NUM_LOOK-1:0]                o_look_hit,
  output logic [NUM_LOOK*c_CORE_DW-1:0]      o_look_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]        r_head;
  logic [PW-1:0]        r_tail;
  logic [CW-1:0]        r_count;
  logic [ADDR_W-1:0]    r_addr [DEPTH];
  logic [c_CORE_DW-1:0] r_data [DEPTH];

  logic [PW-1:0]        w_slot [NUM_ENQ];
  logic [CW-1:0]        w_nenq;

  // Each asserted lane takes the slot after those of the lower lanes, so
  // program order inside a cycle is lane index order. The caller never asks
  // for more lanes than there are free slots.
  always_comb begin
    w_nenq = '0;
    for (int i = 0; i < NUM_ENQ; i++) begin
      w_slot[i] = r_tail + w_nenq[PW-1:0];
      w_nenq    = w_nenq + CW'(i_enq[i]);
    end
  end

  assign o_drain     = (r_count != '0);
  assign o_head_addr = r_addr[r_head];
  assign o_head_data = r_data[r_head];
  assign o_count     = r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_tail  <= r_tail + w_nenq[PW-1:0];
      r_count <= r_count + w_nenq - CW'(o_drain);
      if (o_drain) begin
        r_head <= r_head + PW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NUM_ENQ; i++) begin
      if (i_enq[i] && !i_rst) begin
        r_addr[w_slot[i]] <= i_enq_addr[i*ADDR_W +: ADDR_W];
        r_data[w_slot[i]] <= i_enq_data[i*c_CORE_DW +: c_CORE_DW];
      end
    end
  end

  // Scan oldest to youngest so the last hit (youngest) wins.
  for (genvar g = 0; g < NUM_LOOK; g++) begin : g_look
    logic [ADDR_W-1:0]    w_qaddr;
    logic                 w_hit;
    logic [c_CORE_DW-1:0] w_data;
    logic [PW-1:0]        w_idx;

    assign w_qaddr = i_look_addr[g*ADDR_W +: ADDR_W];

    always_comb begin
      w_hit  = 1'b0;
      w_data = '0;
      w_idx  = r_head;
      for (int j = 0; j < DEPTH; j++) begin
        w_idx = r_head + PW'(j);
        if ((CW'(j) < r_count) && (r_addr[w_idx] == w_qaddr)) begin
          w_hit  = 1'b1;
          w_data = r_data[w_idx];
        end
      end
    end

    assign o_look_hit[g]                           = w_hit;
    assign o_look_data[g*c_CORE_DW +: c_CORE_DW]   = w_data;
  end

endmodule
`default_nettype wire

// File: rtl/dram_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : dram_responder                                                |
// | Purpose    : Byte-wide DRAM model serving NUM_CORES core ports and one     |
// |              host port. Writes are posted through dram_wbuf; reads see     |
// |              the youngest pending write, else the array byte.              |
// | Ports      : i_clk, i_rst; i_core_addr/i_core_read/i_core_write/           |
// |              i_core_wdata/o_core_rdata (per-core slices); host (handshake  |
// |              interface, slave side); o_wb_count; o_overflow (sticky).      |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module dram_responder
  import dram_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = c_ADDR_W,
  parameter int WB_DEPTH  = c_WB_DEPTH
) (
  input  wire logic                           i_clk,
  input  wire logic                           i_rst,
  input  wire logic [c_CORE_AW*NUM_CORES-1:0] i_core_addr,
  input  wire logic [NUM_CORES-1:0]           i_core_read,
  input  wire logic [NUM_CORES-1:0]           i_core_write,
  input  wire logic [c_CORE_DW*NUM_CORES-1:0] i_core_wdata,
  output logic [c_CORE_DW*NUM_CORES-1:0]      o_core_rdata,
  dram_responder_if.slave                     host,
  output logic [$clog2(WB_DEPTH):0]           o_wb_count,
  output logic                                o_overflow
);

  localparam int CW = $clog2(WB_DEPTH) + 1;
  localparam int NE = NUM_CORES + 1;  // lane NUM_CORES is the host

  logic [c_CORE_DW-1:0] r_mem [2**ADDR_W];
  host_state_t          r_state;
  logic                 r_rvalid;
  logic [c_CORE_DW-1:0] r_rdata;
  logic                 r_overflow;

  logic [NE*ADDR_W-1:0]    w_addr;
  logic [NE*c_CORE_DW-1:0] w_wdata;
  logic [NE-1:0]           w_enq;
  logic [NE-1:0]           w_hit;
  logic [NE*c_CORE_DW-1:0] w_bdata;
  logic [c_CORE_DW-1:0]    w_fwd [NE];
  logic [NUM_CORES-1:0]    w_enq_core;
  logic [CW-1:0]           w_count;
  logic [CW-1:0]           w_free;
  logic [CW-1:0]           w_used;
  logic                    w_drop;
  logic                    w_drain;
  logic [ADDR_W-1:0]       w_head_addr;
  logic [c_CORE_DW-1:0]    w_head_data;
  logic                    w_ready;
  logic                    w_host_wr;
  logic                    w_host_rd;
  logic                    w_unused;

  // Read strobes are status only and upper address bits alias away.
  assign w_unused = ^{i_core_read, i_core_addr, host.i_host_addr};

  for (genvar k = 0; k < NUM_CORES; k++) begin : g_core
    assign w_addr[k*ADDR_W +: ADDR_W]        = i_core_addr[k*c_CORE_AW +: ADDR_W];
    assign w_wdata[k*c_CORE_DW +: c_CORE_DW] = i_core_wdata[k*c_CORE_DW +: c_CORE_DW];
    assign o_core_rdata[k*c_CORE_DW +: c_CORE_DW] = w_fwd[k];
  end

  assign w_addr[NUM_CORES*ADDR_W +: ADDR_W]        = host.i_host_addr[ADDR_W-1:0];
  assign w_wdata[NUM_CORES*c_CORE_DW +: c_CORE_DW] = host.i_host_wdata;

  for (genvar j = 0; j < NE; j++) begin : g_fwd
    assign w_fwd[j] = w_hit[j] ? w_bdata[j*c_CORE_DW +: c_CORE_DW]
                               : r_mem[w_addr[j*ADDR_W +: ADDR_W]];
  end

  // A slot freed by this cycle's drain is reusable in the same cycle.
  // Accepting lowest core index first means overflow drops the highest.
  always_comb begin
    w_free     = CW'(WB_DEPTH) - w_count + CW'(w_drain);
    w_used     = '0;
    w_enq_core = '0;
    w_drop     = 1'b0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (i_core_write[k]) begin
        if (w_used < w_free) begin
          w_enq_core[k] = 1'b1;
          w_used        = w_used + CW'(1);
        end else begin
          w_drop = 1'b1;
        end
      end
    end
  end

  // The host only gets a slot when no core competes, so it always fits.
  assign w_ready   = (r_state == ST_IDLE) && !(|i_core_write) &&
                     (w_count != CW'(WB_DEPTH));
  assign w_host_wr = host.i_host_valid && w_ready && host.i_host_write;
  assign w_host_rd = host.i_host_valid && w_ready && !host.i_host_write;
  assign w_enq     = {w_host_wr, w_enq_core};

  dram_wbuf #(
    .NUM_ENQ  (NE),
    .NUM_LOOK (NE),
    .ADDR_W   (ADDR_W),
    .DEPTH    (WB_DEPTH)
  ) u_wbuf (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_enq       (w_enq),
    .i_enq_addr  (w_addr),
    .i_enq_data  (w_wdata),
    .o_drain     (w_drain),
    .o_head_addr (w_head_addr),
    .o_head_data (w_head_data),
    .o_count     (w_count),
    .i_look_addr (w_addr),
    .o_look_hit  (w_hit),
    .o_look_data (w_bdata)
  );

  // Array is never reset; a drain is suppressed in a reset cycle so the
  // discarded head entry does not land.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_drain) begin
      r_mem[w_head_addr] <= w_head_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_host_rd) begin
            r_rdata  <= w_fwd[NUM_CORES];
            r_rvalid <= 1'b1;
            r_state  <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_rvalid <= 1'b0;
          r_state  <= ST_IDLE;
        end
        default: begin
          r_rvalid <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign host.o_host_ready  = w_ready;
  assign host.o_host_rvalid = r_rvalid;
  assign host.o_host_rdata  = r_rdata;
  assign o_wb_count         = w_count;
  assign o_overflow         = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_dram_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_dram_responder                                             |
// | Purpose    : Directed self-checking bench for dram_responder: forwarding,  |
// |              same-cycle ordering, overflow drops, aliasing, host read      |
// |              latency and reset behaviour.                                  |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module tb_dram_responder;
  import dram_pkg::*;

  localparam int NC = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [16*NC-1:0] core_addr;
  logic [NC-1:0]   core_read;
  logic [NC-1:0]   core_write;
  logic [8*NC-1:0] core_wdata;
  logic [8*NC-1:0] core_rdata;
  logic [3:0]      wb_count;
  logic            overflow;

  int n_tests = 0;
  int n_fail  = 0;

  dram_responder_if hif ();

  dram_responder #(
    .NUM_CORES (NC),
    .ADDR_W    (12),
    .WB_DEPTH  (8)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_core_addr  (core_addr),
    .i_core_read  (core_read),
    .i_core_write (core_write),
    .i_core_wdata (core_wdata),
    .o_core_rdata (core_rdata),
    .host         (hif),
    .o_wb_count   (wb_count),
    .o_overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    core_addr  = '0;
    core_read  = '0;
    core_write = '0;
    core_wdata = '0;
    hif.i_host_valid = 1'b0;
    hif.i_host_write = 1'b0;
    hif.i_host_addr  = '0;
    hif.i_host_wdata = '0;
  endtask

  // Inputs change 1 time unit after the rising edge; checks sample 2 units later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic core_wr(input int k, input logic [15:0] a, input logic [7:0] d);
    core_write[k]         = 1'b1;
    core_addr[16*k +: 16] = a;
    core_wdata[8*k +: 8]  = d;
  endtask

  task automatic core_rd(input int k, input logic [15:0] a);
    core_read[k]          = 1'b1;
    core_addr[16*k +: 16] = a;
  endtask

  function automatic logic [7:0] rd(input int k);
    return core_rdata[8*k +: 8];
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (2) next_cycle();
    #2;
    chk("rst_count",  wb_count, 0);
    chk("rst_ovf",    overflow, 0);
    chk("rst_rvalid", hif.o_host_rvalid, 0);
    chk("rst_rdata",  hif.o_host_rdata, 0);
    chk("rst_ready",  hif.o_host_ready, 1);

    // Core0 write, core1 forwarded read, then array read after drain.
    next_cycle(); rst = 1'b0;
    core_wr(0, 16'h0010, 8'h5A); #2;
    chk("ready_low_corewr", hif.o_host_ready, 0);
    next_cycle(); core_rd(1, 16'h0010); #2;
    chk("fwd_core1",  rd(1), 8'h5A);
    chk("count_one",  wb_count, 1);
    next_cycle(); core_rd(1, 16'h0010); #2;
    chk("drained_core1", rd(1), 8'h5A);
    chk("count_zero",    wb_count, 0);

    // Same-cycle writes to one address: higher core index wins.
    next_cycle(); core_wr(0, 16'h0100, 8'h11); core_wr(2, 16'h0100, 8'h22);
    next_cycle(); core_rd(3, 16'h0100); #2;
    chk("samecyc_fwd",   rd(3), 8'h22);
    chk("samecyc_count", wb_count, 2);
    next_cycle();
    next_cycle(); core_rd(3, 16'h0100); #2;
    chk("samecyc_array", rd(3), 8'h22);
    chk("samecyc_empty", wb_count, 0);

    // A same-cycle write is not visible to a read in that cycle.
    next_cycle(); core_wr(0, 16'h0100, 8'h33); core_rd(1, 16'h0100); #2;
    chk("no_samecyc_fwd", rd(1), 8'h22);
    next_cycle(); core_rd(1, 16'h0100); #2;
    chk("next_cyc_fwd", rd(1), 8'h33);
    next_cycle();

    // Host write with aliasing address.
    next_cycle();
    hif.i_host_valid = 1'b1; hif.i_host_write = 1'b1;
    hif.i_host_addr = 16'h1005; hif.i_host_wdata = 8'hA5; #2;
    chk("host_wr_ready", hif.o_host_ready, 1);
    next_cycle(); core_rd(0, 16'h0005); core_rd(2, 16'h2005); #2;
    chk("alias_c0", rd(0), 8'hA5);
    chk("alias_c2", rd(2), 8'hA5);
    chk("host_wr_count", wb_count, 1);
    next_cycle();

    // Host read from the array: one-cycle latency, single-cycle rvalid.
    next_cycle(); core_wr(0, 16'h0020, 8'h77);
    next_cycle();
    next_cycle();
    hif.i_host_valid = 1'b1; hif.i_host_addr = 16'h0020; #2;
    chk("host_rd_ready", hif.o_host_ready, 1);
    chk("host_rd_rv0",   hif.o_host_rvalid, 0);
    next_cycle(); #2;
    chk("host_rd_rvalid", hif.o_host_rvalid, 1);
    chk("host_rd_rdata",  hif.o_host_rdata, 8'h77);
    chk("host_rd_busy",   hif.o_host_ready, 0);
    next_cycle(); #2;
    chk("host_rd_rv_end", hif.o_host_rvalid, 0);
    chk("host_rd_idle",   hif.o_host_ready, 1);

    // Host read forwarded from the buffer.
    next_cycle(); core_wr(1, 16'h0030, 8'h99);
    next_cycle(); hif.i_host_valid = 1'b1; hif.i_host_addr = 16'h0030; #2;
    chk("host_fwd_ready", hif.o_host_ready, 1);
    next_cycle(); #2;
    chk("host_fwd_rvalid", hif.o_host_rvalid, 1);
    chk("host_fwd_rdata",  hif.o_host_rdata, 8'h99);

    // Overflow: preload the two addresses that will be dropped.
    next_cycle(); core_wr(0, 16'h0222, 8'hEE); core_wr(1, 16'h0223, 8'hEE);
    repeat (3) next_cycle();
    #2; chk("ovf_pre_empty", wb_count, 0);
    for (int k = 0; k < 3; k++) begin
      int exp_cnt;
      next_cycle();
      for (int c = 0; c < NC; c++) core_wr(c, 16'h0200 + 16'(16*k + c), 8'(16*k + c));
      #2;
      exp_cnt = (k == 0) ? 0 : (k == 1) ? 4 : 7;
      chk($sformatf("ovf_count_k%0d", k), wb_count, exp_cnt);
      chk($sformatf("ovf_flag_k%0d", k), overflow, 0);
    end
    next_cycle(); #2;
    chk("ovf_full_count", wb_count, 8);
    chk("ovf_flag_set",   overflow, 1);
    chk("ovf_full_ready", hif.o_host_ready, 0);
    repeat (9) next_cycle();
    #2; chk("ovf_drained", wb_count, 0);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      for (int c = 0; c < NC; c++) core_rd(c, 16'h0200 + 16'(16*k + c));
      #2;
      for (int c = 0; c < NC; c++)
        chk($sformatf("ovf_data_k%0d_c%0d", k, c), rd(c),
            (k == 2 && c >= 2) ? 8'hEE : 8'(16*k + c));
    end

    // Reset with five pending writes.
    next_cycle(); for (int c = 0; c < NC; c++) core_wr(c, 16'h0301 + 16'(c), 8'hC1 + 8'(c));
    next_cycle(); core_wr(0, 16'h0305, 8'hC5);
    repeat (6) next_cycle();
    next_cycle(); for (int c = 0; c < NC; c++) core_wr(c, 16'h0300 + 16'(c), 8'hD0 + 8'(c));
    next_cycle(); core_wr(0, 16'h0304, 8'hD4); core_wr(1, 16'h0305, 8'hD5);
    next_cycle(); rst = 1'b1;
    hif.i_host_valid = 1'b1; hif.i_host_addr = 16'h0301; #2;
    chk("prerst_count", wb_count, 5);
    chk("prerst_ovf",   overflow, 1);
    next_cycle(); rst = 1'b0;
    for (int c = 0; c < NC; c++) core_rd(c, 16'h0300 + 16'(c));
    #2;
    chk("postrst_count",  wb_count, 0);
    chk("postrst_ovf",    overflow, 0);
    chk("postrst_rvalid", hif.o_host_rvalid, 0);
    chk("postrst_rdata",  hif.o_host_rdata, 0);
    chk("postrst_m300", rd(0), 8'hD0);
    chk("postrst_m301", rd(1), 8'hC1);
    chk("postrst_m302", rd(2), 8'hC2);
    chk("postrst_m303", rd(3), 8'hC3);
    next_cycle(); core_rd(0, 16'h0304); core_rd(1, 16'h0305); #2;
    chk("postrst_m304", rd(0), 8'hC4);
    chk("postrst_m305", rd(1), 8'hC5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dram_responder.md
DRAM_RESPONDER -- requirements
Module: dram_responder

Interface
REQ-001 Parameter NUM_CORES, default 4: number of core DRAM ports served.
REQ-002 Parameter ADDR_W, default 12: array depth is 2^ADDR_W bytes.
REQ-003 Parameter WB_DEPTH, default 8: posted-write buffer entries (power of two).
REQ-004 Port i_clk  in  1  single clock; all state updates on its rising edge.
REQ-005 Port i_rst  in  1  reset; synchronous and active-high.
REQ-006 Port i_core_addr  in  16*NUM_CORES  per-core byte address; core k occupies bits [16k+15:16k].
REQ-007 Port i_core_read  in  NUM_CORES  per-core read strobe (status only; it does not gate data).
REQ-008 Port i_core_write  in  NUM_CORES  per-core write strobe.
REQ-009 Port i_core_wdata  in  8*NUM_CORES  per-core write byte.
REQ-010 Port o_core_rdata  out  8*NUM_CORES  per-core read byte.
REQ-011 Port i_host_valid / i_host_write  in  1 / 1  host request and its direction (1 = write).
REQ-012 Port i_host_addr / i_host_wdata  in  16 / 8  host address and write byte.
REQ-013 Port o_host_ready  out  1  host request accepted when valid and ready are both high.
REQ-014 Port o_host_rvalid / o_host_rdata  out  1 / 8  host read response.
REQ-015 Port o_wb_count  out  $clog2(WB_DEPTH)+1  current write-buffer occupancy.
REQ-016 Port o_overflow  out  1  sticky: a write was dropped.

Function
REQ-017 Only address bits [ADDR_W-1:0] are used; higher bits are ignored, so addresses alias with wrap-around.
REQ-018 o_core_rdata[k] is combinational in the same cycle and returns the youngest pending buffer entry matching that address, else the array byte.
REQ-019 Writes are posted. Each cycle, asserted core writes enqueue in ascending core index; an accepted host write enqueues after them.
REQ-020 The oldest buffer entry drains into the array each cycle while the buffer is non-empty; enqueue and drain may occur in the same cycle.
REQ-021 Free slots for enqueue = WB_DEPTH - count + (1 if a drain occurs this cycle).
REQ-022 Core writes exceeding the free slots are dropped, highest index first, and o_overflow sets.
REQ-023 o_host_ready is high only when the host FSM is IDLE, no core write is asserted, and the buffer is not full.
REQ-024 Host FSM states are IDLE and RESP.
REQ-025 In IDLE, an accepted host read captures the forwarded data (same rule as REQ-018) and moves to RESP; an accepted host write stays in IDLE.
REQ-026 RESP lasts exactly one cycle, drives o_host_rvalid=1 with the captured byte, then returns to IDLE; a host read therefore has 1-cycle latency.
REQ-027 Two writes to the same address in one cycle both enqueue, so after draining the higher-index core's byte remains.
REQ-028 o_core_rdata reflects writes enqueued in earlier cycles only, never same-cycle writes.

Reset
REQ-029 While i_rst is high, the buffer empties, pending writes are discarded, o_wb_count=0, o_overflow=0, FSM=IDLE, o_host_rvalid=0, o_host_rdata=0.
REQ-030 Array contents are not cleared by reset.
REQ-031 A host read accepted in the reset cycle is discarded.

Structure
REQ-032 Shared header/package dram_pkg holds the default ADDR_W and WB_DEPTH, the host FSM state encodings, and the per-core slice width constants (16 address, 8 data).
REQ-033 Sub-module dram_wbuf holds the circular FIFO with multi-enqueue and single drain, plus the youngest-match forwarding lookup; the top level holds the array, the arbitration and the host FSM.

Verification
REQ-034 Core0 writes 0x5A to address 0x0010 in cycle n -> core1 reading 0x0010 in cycle n+1 gets 0x5A (forwarded), and still 0x5A after the buffer drains.
REQ-035 All 4 cores write in each of 3 consecutive cycles, starting from empty -> o_wb_count goes 4, 7, 8(full) with drops, o_overflow=1, and exactly the highest-index writes are missing.
REQ-036 Core0 and core2 write 0x11 and 0x22 to 0x0100 in the same cycle -> after drain, a read of 0x0100 returns 0x22.
REQ-037 Host write 0xA5 to 0x1005 with ADDR_W=12 -> a core read of 0x0005 returns 0xA5; o_host_ready is low during any cycle with a core write.
REQ-038 Host read of 0x0020 accepted in cycle n -> o_host_rvalid=1 in cycle n+1 only, o_host_ready=0 in cycle n+1.
REQ-039 i_rst asserted with 5 pending writes -> o_wb_count=0 and o_overflow=0 next cycle; array bytes of undrained writes are unchanged.
